id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection.
- Sits between decode and execute. Supplies ID_EX_rs / ID_EX_rt and the resolved destination register to the EX-stage forwarding unit, and ID_EX_writeReg onward to the EX/MEM register.
- Inserts a one-cycle bubble on a load-use hazard and drives the PC / IF-ID write-disable.

---
 rtl/id_ex_stage_reg.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection.
//
// Captures decoded controls, operands and register specifiers from decode
// and presents them to execute one cycle later. The destination register
// is resolved at capture time (regDst ? rd : rt). When the instruction in
// EX is a load whose rt is a source of the instruction in decode, the
// register inserts one bubble and raises stall so PC and IF/ID hold.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   IF_ID_*             decode-stage register specifiers and rt-use flag
//   regWrite..aluOp     decoded control fields
//   readData1/2, signExtImm  decode-stage operands
//   flush               squash decode instruction (bubble, overrides stall)
//   hold                global freeze: nothing updates
//   stall               combinational load-use stall to PC / IF/ID
//   ID_EX_*             registered stage contents
//
// Optional feature (define ID_EX_STALL_CNT_EN):
//   stall_count         saturating count of inserted load-use bubbles

module id_ex_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         IF_ID_rs,
    input  logic [4:0]         IF_ID_rt,
    input  logic [4:0]         IF_ID_rd,
    input  logic               IF_ID_useRt,
    input  logic               regWrite,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic               memToReg,
    input  logic               regDst,
    input  logic               aluSrc,
    input  logic [ALUOP_W-1:0] aluOp,
    input  logic [DATA_W-1:0]  readData1,
    input  logic [DATA_W-1:0]  readData2,
    input  logic [DATA_W-1:0]  signExtImm,
    input  logic               flush,
    input  logic               hold,
    output logic               stall,
    output logic               ID_EX_valid,
    output logic               ID_EX_regWrite,
    output logic               ID_EX_memRead,
    output logic               ID_EX_memWrite,
    output logic               ID_EX_memToReg,
    output logic               ID_EX_aluSrc,
    output logic [ALUOP_W-1:0] ID_EX_aluOp,
    output logic [DATA_W-1:0]  ID_EX_readData1,
    output logic [DATA_W-1:0]  ID_EX_readData2,
    output logic [DATA_W-1:0]  ID_EX_imm,
    output logic [4:0]         ID_EX_rs,
    output logic [4:0]         ID_EX_rt,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]        stall_count,
`endif
    output logic [4:0]         ID_EX_writeReg
);

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic [DATA_W-1:0]  rd1;
        logic [DATA_W-1:0]  rd2;
        logic [DATA_W-1:0]  imm;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         write_reg;
    } stage_t;

    stage_t stage_q, stage_d, capture;
    logic   hz;

    // Load in EX whose rt feeds the decode instruction; $0 never conflicts.
    always_comb begin
        hz = stage_q.valid && stage_q.mem_read && (stage_q.rt != 5'd0) &&
             ((stage_q.rt == IF_ID_rs) || (IF_ID_useRt && (stage_q.rt == IF_ID_rt)));
    end

    // Flush wins over stall so the PC can load the branch/jump target.
    assign stall = hz && !flush;

    always_comb begin
        capture            = '0;
        capture.valid      = 1'b1;
        capture.reg_write  = regWrite;
        capture.mem_read   = memRead;
        capture.mem_write  = memWrite;
        capture.mem_to_reg = memToReg;
        capture.alu_src    = aluSrc;
        capture.alu_op     = aluOp;
        capture.rd1        = readData1;
        capture.rd2        = readData2;
        capture.imm        = signExtImm;
        capture.rs         = IF_ID_rs;
        capture.rt         = IF_ID_rt;
        capture.write_reg  = regDst ? IF_ID_rd : IF_ID_rt;
    end

    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            // An all-zero bubble has regWrite = 0 and rs/rt = 0, so it is
            // never a forwarding source nor a hazard source.
            if (flush || hz) begin
                stage_d = '0;
            end else begin
                stage_d = capture;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ID_EX_valid     = stage_q.valid;
    assign ID_EX_regWrite  = stage_q.reg_write;
    assign ID_EX_memRead   = stage_q.mem_read;
    assign ID_EX_memWrite  = stage_q.mem_write;
    assign ID_EX_memToReg  = stage_q.mem_to_reg;
    assign ID_EX_aluSrc    = stage_q.alu_src;
    assign ID_EX_aluOp     = stage_q.alu_op;
    assign ID_EX_readData1 = stage_q.rd1;
    assign ID_EX_readData2 = stage_q.rd2;
    assign ID_EX_imm       = stage_q.imm;
    assign ID_EX_rs        = stage_q.rs;
    assign ID_EX_rt        = stage_q.rt;
    assign ID_EX_writeReg  = stage_q.write_reg;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Only load-use bubbles count; flush bubbles and frozen cycles do not.
    always_comb begin
        cnt_d = cnt_q;
        if (hz && !flush && !hold && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IF_ID_rs, IF_ID_rt, IF_ID_rd;
    logic        IF_ID_useRt;
    logic        regWrite, memRead, memWrite, memToReg, regDst, aluSrc;
    logic [2:0]  aluOp;
    logic [31:0] readData1, readData2, signExtImm;
    logic        flush, hold;
    logic        stall;
    logic        ID_EX_valid, ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite;
    logic        ID_EX_memToReg, ID_EX_aluSrc;
    logic [2:0]  ID_EX_aluOp;
    logic [31:0] ID_EX_readData1, ID_EX_readData2, ID_EX_imm;
    logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_writeReg;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    id_ex_stage_reg #(.DATA_W(32), .ALUOP_W(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_rs        (IF_ID_rs),
        .IF_ID_rt        (IF_ID_rt),
        .IF_ID_rd        (IF_ID_rd),
        .IF_ID_useRt     (IF_ID_useRt),
        .regWrite        (regWrite),
        .memRead         (memRead),
        .memWrite        (memWrite),
        .memToReg        (memToReg),
        .regDst          (regDst),
        .aluSrc          (aluSrc),
        .aluOp           (aluOp),
        .readData1       (readData1),
        .readData2       (readData2),
        .signExtImm      (signExtImm),
        .flush           (flush),
        .hold            (hold),
        .stall           (stall),
        .ID_EX_valid     (ID_EX_valid),
        .ID_EX_regWrite  (ID_EX_regWrite),
        .ID_EX_memRead   (ID_EX_memRead),
        .ID_EX_memWrite  (ID_EX_memWrite),
        .ID_EX_memToReg  (ID_EX_memToReg),
        .ID_EX_aluSrc    (ID_EX_aluSrc),
        .ID_EX_aluOp     (ID_EX_aluOp),
        .ID_EX_readData1 (ID_EX_readData1),
        .ID_EX_readData2 (ID_EX_readData2),
        .ID_EX_imm       (ID_EX_imm),
        .ID_EX_rs        (ID_EX_rs),
        .ID_EX_rt        (ID_EX_rt),
`ifdef ID_EX_STALL_CNT_EN
        .stall_count     (stall_count),
`endif
        .ID_EX_writeReg  (ID_EX_writeReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic        use_rt, rw, mr, mw, m2r, rdst, asrc;
        logic [2:0]  alu_op;
        logic [31:0] rd1, rd2, imm;
        logic        flush, hold;
    } in_t;

    // Instruction sitting in EX, as seen by the outside world.
    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, asrc;
        logic [2:0]  alu_op;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, wr;
    } ex_t;

    typedef struct packed {
        in_t        in;
        logic       exp_stall;
        logic       exp_valid;
        logic [4:0] exp_wr, exp_rs, exp_rt;
        logic       exp_rw;
    } vec_t;

    ex_t dut_ex;
    assign dut_ex = {ID_EX_valid, ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite,
                     ID_EX_memToReg, ID_EX_aluSrc, ID_EX_aluOp, ID_EX_readData1,
                     ID_EX_readData2, ID_EX_imm, ID_EX_rs, ID_EX_rt, ID_EX_writeReg};

    int  n_vec = 0;
    int  n_err = 0;
    ex_t m_ex  = '0;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] m_cnt = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ex(input string name, input ex_t act, input ex_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic use_rt, input logic rw, input logic mr,
                               input logic mw, input logic m2r, input logic rdst,
                               input logic asrc, input logic fl);
        in_t v;
        v        = '0;
        v.rs     = rs;
        v.rt     = rt;
        v.rd     = rd;
        v.use_rt = use_rt;
        v.rw     = rw;
        v.mr     = mr;
        v.mw     = mw;
        v.m2r    = m2r;
        v.rdst   = rdst;
        v.asrc   = asrc;
        v.alu_op = 3'd2;
        v.rd1    = 32'hA000_0000 | 32'(rs);
        v.rd2    = 32'hB000_0000 | 32'(rt);
        v.imm    = 32'hC000_0000 | 32'(rd);
        v.flush  = fl;
        return v;
    endfunction

    task automatic drive(input in_t v);
        IF_ID_rs    = v.rs;
        IF_ID_rt    = v.rt;
        IF_ID_rd    = v.rd;
        IF_ID_useRt = v.use_rt;
        regWrite    = v.rw;
        memRead     = v.mr;
        memWrite    = v.mw;
        memToReg    = v.m2r;
        regDst      = v.rdst;
        aluSrc      = v.asrc;
        aluOp       = v.alu_op;
        readData1   = v.rd1;
        readData2   = v.rd2;
        signExtImm  = v.imm;
        flush       = v.flush;
        hold        = v.hold;
    endtask

    // Reference: a load in EX conflicts with any source the decode instruction reads.
    function automatic logic m_hz(input ex_t e, input in_t v);
        return e.valid && e.mr && (e.rt != 5'd0) &&
               ((e.rt == v.rs) || (v.use_rt && (e.rt == v.rt)));
    endfunction

    function automatic ex_t m_next(input ex_t e, input in_t v);
        ex_t n;
        if (v.hold) return e;
        if (v.flush || m_hz(e, v)) return '0;
        n = {1'b1, v.rw, v.mr, v.mw, v.m2r, v.asrc, v.alu_op, v.rd1, v.rd2, v.imm,
             v.rs, v.rt, (v.rdst ? v.rd : v.rt)};
        return n;
    endfunction

    // One clock: drive at negedge, check stall, advance through posedge, check regs.
    task automatic cycle(input in_t v, output logic st, output ex_t o);
        @(negedge clk);
        drive(v);
        #1;
        st = stall;
        chk("stall_model", 32'(st), 32'(m_hz(m_ex, v) && !v.flush));
`ifdef ID_EX_STALL_CNT_EN
        if (m_hz(m_ex, v) && !v.flush && !v.hold && (m_cnt != 32'hFFFF_FFFF)) m_cnt++;
`endif
        m_ex = m_next(m_ex, v);
        @(posedge clk);
        #1;
        o = dut_ex;
        chk_ex("regs_model", o, m_ex);
`ifdef ID_EX_STALL_CNT_EN
        chk("count_model", stall_count, m_cnt);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        in_t  v, lw5, add5;
        logic st;
        ex_t  o;

        //                 rs  rt  rd  useRt rw mr mw m2r rdst asrc fl   stall valid wr rs rt rw
        tbl[0]  = '{mk(1,  2,  3,  1, 1, 0, 0, 0, 1, 0, 0), 0, 1, 3, 1, 2, 1}; // add $3,$1,$2
        tbl[1]  = '{mk(1,  5,  0,  0, 1, 1, 0, 1, 0, 1, 0), 0, 1, 5, 1, 5, 1}; // lw $5
        tbl[2]  = '{mk(5,  2,  6,  1, 1, 0, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0}; // add rs=5: bubble
        tbl[3]  = '{mk(5,  2,  6,  1, 1, 0, 0, 0, 1, 0, 0), 0, 1, 6, 5, 2, 1}; // add captured
        tbl[4]  = '{mk(2,  0,  0,  0, 1, 1, 0, 1, 0, 1, 0), 0, 1, 0, 2, 0, 1}; // lw $0
        tbl[5]  = '{mk(0,  3,  7,  1, 1, 0, 0, 0, 1, 0, 0), 0, 1, 7, 0, 3, 1}; // rs=0 no hazard
        tbl[6]  = '{mk(1,  5,  0,  0, 1, 1, 0, 1, 0, 1, 0), 0, 1, 5, 1, 5, 1}; // lw $5
        tbl[7]  = '{mk(4,  5,  0,  0, 1, 0, 0, 0, 0, 1, 0), 0, 1, 5, 4, 5, 1}; // addi rt=5, no rt use
        tbl[8]  = '{mk(4,  8,  0,  0, 1, 1, 0, 1, 0, 1, 0), 0, 1, 8, 4, 8, 1}; // lw $8
        tbl[9]  = '{mk(1,  8,  0,  1, 0, 0, 1, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0}; // sw uses rt=8: bubble
        tbl[10] = '{mk(1,  8,  0,  1, 0, 0, 1, 0, 0, 1, 0), 0, 1, 8, 1, 8, 0}; // sw captured
        tbl[11] = '{mk(2,  9,  0,  0, 1, 1, 0, 1, 0, 1, 0), 0, 1, 9, 2, 9, 1}; // lw $9
        tbl[12] = '{mk(9,  2,  6,  1, 1, 0, 0, 0, 1, 0, 1), 0, 0, 0, 0, 0, 0}; // hazard + flush

        rst_n = 1'b0;
        drive(mk(7, 7, 7, 1, 1, 1, 1, 1, 1, 1, 0));
        #7;
        chk_ex("reset_regs", dut_ex, '0);
        chk("reset_stall", 32'(stall), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        chk("reset_count", stall_count, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].in, st, o);
            chk($sformatf("tbl%0d_stall", i), 32'(st), 32'(tbl[i].exp_stall));
            chk($sformatf("tbl%0d_fields", i), 32'({o.valid, o.wr, o.rs, o.rt, o.rw}),
                32'({tbl[i].exp_valid, tbl[i].exp_wr, tbl[i].exp_rs, tbl[i].exp_rt,
                     tbl[i].exp_rw}));
        end
`ifdef ID_EX_STALL_CNT_EN
        chk("tbl_count", stall_count, 32'd2);
`endif

        // Hold during a pending load-use hazard.
        lw5  = mk(1, 5, 0, 0, 1, 1, 0, 1, 0, 1, 0);
        add5 = mk(5, 2, 6, 1, 1, 0, 0, 0, 1, 0, 0);
        cycle(lw5, st, o);
        for (int i = 0; i < 3; i++) begin
            v      = add5;
            v.hold = 1'b1;
            v.rd1  = $urandom;
            v.rd   = 5'(i + 10);
            cycle(v, st, o);
            chk("hold_stall", 32'(st), 32'd1);
            chk("hold_frozen", 32'({o.valid, o.mr, o.wr}), 32'({1'b1, 1'b1, 5'd5}));
            chk("hold_data", o.rd1, lw5.rd1);
        end
        cycle(add5, st, o);
        chk("hold_release_stall", 32'(st), 32'd1);
        chk_ex("hold_release_bubble", o, '0);
        cycle(add5, st, o);
        chk("after_bubble_stall", 32'(st), 32'd0);
        chk("after_bubble_capture", 32'({o.valid, o.wr, o.rs}), 32'({1'b1, 5'd6, 5'd5}));
`ifdef ID_EX_STALL_CNT_EN
        chk("hold_count", stall_count, 32'd3);
`endif

        // Asynchronous reset between edges with a valid load in EX.
        cycle(lw5, st, o);
        @(negedge clk);
        drive(add5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_ex("midreset_regs", dut_ex, '0);
        chk("midreset_stall", 32'(stall), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        chk("midreset_count", stall_count, 32'd0);
        m_cnt = '0;
`endif
        m_ex = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            v        = '0;
            v.rs     = 5'($urandom_range(0, 7));
            v.rt     = 5'($urandom_range(0, 7));
            v.rd     = 5'($urandom_range(0, 7));
            v.use_rt = 1'($urandom);
            v.rw     = 1'($urandom);
            v.mr     = ($urandom_range(0, 9) < 4);
            v.mw     = 1'($urandom);
            v.m2r    = 1'($urandom);
            v.rdst   = 1'($urandom);
            v.asrc   = 1'($urandom);
            v.alu_op = 3'($urandom);
            v.rd1    = $urandom;
            v.rd2    = $urandom;
            v.imm    = $urandom;
            v.flush  = ($urandom_range(0, 9) == 0);
            v.hold   = ($urandom_range(0, 19) < 3);
            cycle(v, st, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
